// File: rtl/cpu_run_ctrl.sv
// Run-lifecycle sequencer for SingleCycleCPU: streams a program into instruction
// memory, holds the CPU in reset until told to run, counts run cycles and stops the
// CPU when it fetches a halt instruction (ecall or a jal-to-self loop).
// Optional feature: define RUN_TIMEOUT_EN to force a halt after MAX_CYCLES run cycles.
module cpu_run_ctrl #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_start,
  input  logic [31:0]       cpu_instr,
  input  logic [31:0]       cpu_pc,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [31:0]       halt_pc,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [ADDR_W:0]   load_cnt
);

  localparam logic [31:0]     InstrEcall   = 32'h0000_0073;
  localparam logic [31:0]     InstrJalSelf = 32'h0000_006F;
  localparam logic [ADDR_W:0] LoadFull     = (ADDR_W + 1)'(IMEM_WORDS);

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseEcall   = 2'b01;
  localparam logic [1:0] CauseJalSelf = 2'b10;
`ifdef RUN_TIMEOUT_EN
  localparam logic [1:0] CauseTimeout = 2'b11;
  localparam logic [CNT_W-1:0] TimeoutAt = CNT_W'(MAX_CYCLES - 1);
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
`endif

  typedef enum logic [2:0] {StIdle, StLoad, StReady, StRun, StHalt} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [1:0]          halt_cause_q, halt_cause_d;
  logic [31:0]         halt_pc_q, halt_pc_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                cpu_start_q;
  logic                accept;

  // Load handshake readiness and state-decoded status flags.
  always_comb begin
    ld_ready = 1'b0;
    case (state_q)
      StIdle, StHalt: ld_ready = 1'b1;
      StLoad:         ld_ready = (load_cnt_q != LoadFull);
      default:        ld_ready = 1'b0;
    endcase
  end

  assign accept = ld_valid & ld_ready;
  assign busy   = (state_q == StLoad) || (state_q == StRun);
  assign done   = (state_q == StHalt);

  // Next-state, load write port and run bookkeeping.
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    halt_cause_d = halt_cause_q;
    halt_pc_d    = halt_pc_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    case (state_q)
      StIdle, StHalt: begin
        if (accept) begin
          // A load always wins over a simultaneous go.
          imem_we_d    = 1'b1;
          imem_addr_d  = '0;
          imem_wdata_d = ld_data;
          load_cnt_d   = (ADDR_W + 1)'(1);
          halt_cause_d = CauseNone;
          state_d      = ld_last ? StReady : StLoad;
        end else if ((state_q == StHalt) && go) begin
          cycle_cnt_d  = '0;
          halt_cause_d = CauseNone;
          state_d      = StRun;
        end
      end
      StLoad: begin
        if (accept) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = load_cnt_q[ADDR_W-1:0];
          imem_wdata_d = ld_data;
          load_cnt_d   = load_cnt_q + 1'b1;
          // Filling the whole memory acts as an implicit last word.
          if (ld_last || (load_cnt_d == LoadFull)) state_d = StReady;
        end
      end
      StReady: begin
        if (go) begin
          cycle_cnt_d = '0;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (cpu_instr == InstrEcall) begin
          halt_cause_d = CauseEcall;
          halt_pc_d    = cpu_pc;
          state_d      = StHalt;
        end else if (cpu_instr == InstrJalSelf) begin
          halt_cause_d = CauseJalSelf;
          halt_pc_d    = cpu_pc;
          state_d      = StHalt;
`ifdef RUN_TIMEOUT_EN
        end else if (cycle_cnt_q == TimeoutAt) begin
          halt_cause_d = CauseTimeout;
          halt_pc_d    = cpu_pc;
          state_d      = StHalt;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; cpu_start follows the next state so it tracks RUN entry/exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      load_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      halt_cause_q <= CauseNone;
      halt_pc_q    <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      halt_cause_q <= halt_cause_d;
      halt_pc_q    <= halt_pc_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_start_q  <= (state_d == StRun);
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_start  = cpu_start_q;
  assign halt_cause = halt_cause_q;
  assign halt_pc    = halt_pc_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign load_cnt   = load_cnt_q;

endmodule
